spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
Parametrised SPI slave that runs entirely in the sysClk_i domain. It synchronises SCLK, MOSI and /SS internally and detects SCLK edges, so no logic is clocked by SCLK. It supports all four CPOL/CPHA modes, any word width, and MSB- or LSB-first ordering. It has a single-entry TX holding register with a ready/load handshake, and flags RX word-complete, TX underrun and frame abort. It sits between an off-chip SPI master and the CPU/peripheral bus.

Parameters:
DATA_WIDTH, 8, bits per SPI word (>=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0: sample on leading edge / shift on trailing; 1: shift on leading / sample on trailing
MSB_FIRST, 1, 1: MSb first on both lines; 0: LSb first
SYNC_STAGES, 2, flops in each input synchroniser (>=2)

Ports:
sysClk_i  in  1  system clock; only clock in the block
reset_i  in  1  synchronous, active-high reset
sclk_i  in  1  async SPI clock from master
mosi_i  in  1  async master-out data
ss_i_n  in  1  async slave select, active low
miso_o  out  1  slave-out data
miso_oe_o  out  1  MISO output enable (1 while selected)
tx_data_i  in  DATA_WIDTH  next word to transmit
tx_load_i  in  1  write tx_data_i into holding register
tx_ready_o  out  1  holding register empty
rx_data_o  out  DATA_WIDTH  last complete received word
rx_valid_o  out  1  one-cycle pulse: rx_data_o updated
tx_underrun_o  out  1  one-cycle pulse: word started with empty holding register
frame_error_o  out  1  one-cycle pulse: /SS deasserted mid-word
busy_o  out  1  frame in progress (ACTIVE state)

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, frame_error_o=0, busy_o=0, bit_cnt=0, state IDLE.
- Synchronisers reset to idle levels (sclk=CPOL, mosi=0, ss=1) so no false edge is seen after reset.
- Edge detect: one register after the sync chain. Leading edge = rising if CPOL=0, falling if CPOL=1. Pin-to-event latency = SYNC_STAGES+1 cycles.
- Requirement: the SCLK half-period is >= SYNC_STAGES+2 sysClk cycles.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other edge.
- FSM IDLE: on synced /SS fall, go to ACTIVE and set bit_cnt=0. If CPHA=0, also perform a word load immediately.
- FSM ACTIVE: on synced /SS rise, go to IDLE. If bit_cnt!=0, pulse frame_error_o and discard the partial word. Edges in IDLE are ignored.
- Word load: if tx_ready_o=0, copy holding to tx_shift and set tx_ready_o=1. Otherwise load all zeros and pulse tx_underrun_o.
- miso_o is the head bit of tx_shift (MSb if MSB_FIRST, else LSb), gated to 0 when miso_oe_o=0.
- miso_oe_o = busy_o.
- Shift edge in ACTIVE: if bit_cnt==0 and this is not the CPHA=0 first word, perform a word load; otherwise shift tx_shift one position toward the head.
- Sample edge: rx_shift takes the synced MOSI (shift-in at the tail) and bit_cnt increments.
- When bit_cnt reaches DATA_WIDTH-1 on a sample edge: rx_data_o gets the full word and rx_valid_o pulses on the next cycle. bit_cnt wraps to 0 and the next word continues seamlessly.
- CPHA=0 consequence: the trailing edge after the last word loads and consumes the holding register (documented, intended).
- Holding register: tx_load_i with tx_ready_o=1 latches tx_data_i and clears tx_ready_o on the next cycle. tx_load_i with tx_ready_o=0 is ignored.
- If a word load and tx_load_i land in the same cycle with tx_ready_o=0, the load takes the old word and tx_load_i is ignored.
- rx_data_o holds its value until the next completed word; there is no backpressure.
- reset_i mid-frame returns all state to reset values. The block resyncs on the next /SS fall.

Test Plan:
- Mode 0, W=8, MSB-first: load 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1. Exactly one rx_valid_o with rx_data_o=0x3C. tx_ready_o returns to 1 (4 cycles) after /SS fall.
- Mode 3: load 0x12; reload 0x34 while word 1 shifts; master sends 0xF0,0x0F in one /SS frame -> MISO 0x12 then 0x34. rx_valid_o pulses twice (0xF0, 0x0F). No underrun.
- Mode 1, no tx_load_i: master sends 0x55 -> MISO all 0, tx_underrun_o pulses once, rx_data_o=0x55.
- Mode 0: /SS rises after 5 SCLK sample edges -> frame_error_o pulses once and no rx_valid_o. The next full frame sending 0x81 gives rx_data_o=0x81.
- DATA_WIDTH=16, CPHA=1, MSB_FIRST=0: load 0xBEEF, master sends 0x1234 -> MISO LSb-first 0xBEEF, rx_data_o=0x1234.
- Assert reset_i after 3 bits of a frame -> outputs at reset values. A new frame sending 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_slave_sync.sv
// SPI slave clocked only by sysClk_i. SCLK, MOSI and /SS are synchronised and SCLK
// edges are detected in the system domain. TX uses a one-word holding register.
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sysClk_i,
  input  logic                  reset_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  ss_i_n,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  frame_error_o,
  output logic                  busy_o
);
  localparam int               CNT_W     = $clog2(DATA_WIDTH);
  localparam logic             SCLK_IDLE = 1'(CPOL);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ss_sync;
  logic                    sclk_s, mosi_s, ss_s, sclk_d, ss_d;
  logic                    sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                    lead_edge, trail_edge, sample_edge, shift_edge;
  logic                    load_word, shift_word, sample_bit, abort;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift, tx_next, hold, rx_shift, rx_next;
  logic                    tx_head;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // Idle-level reset of the chains keeps a fresh reset from looking like an edge.
  always_ff @(posedge sysClk_i) begin
    if (reset_i) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= SCLK_IDLE;
      ss_d      <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      ss_fall   <= ~ss_s & ss_d;
      ss_rise   <= ss_s & ~ss_d;
    end
  end

  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  always_ff @(posedge sysClk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    shift_word = 1'b0;
    sample_bit = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = ACTIVE;
          load_word  = (CPHA == 0);
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_next = IDLE;
          abort      = (bit_cnt != '0);
        end else if (shift_edge) begin
          // A shift edge at a word boundary starts the next word instead of shifting.
          if (bit_cnt == '0) load_word = 1'b1;
          else               shift_word = 1'b1;
        end else if (sample_edge) begin
          sample_bit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (MSB_FIRST != 0) begin
      tx_head = tx_shift[DATA_WIDTH-1];
      tx_next = {tx_shift[DATA_WIDTH-2:0], 1'b0};
      rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    end else begin
      tx_head = tx_shift[0];
      tx_next = {1'b0, tx_shift[DATA_WIDTH-1:1]};
      rx_next = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge sysClk_i) begin
    if (reset_i) begin
      bit_cnt       <= '0;
      tx_shift      <= '0;
      hold          <= '0;
      tx_ready_o    <= 1'b1;
      rx_shift      <= '0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_error_o <= abort;

      if (state != state_next) begin
        bit_cnt <= '0;
      end else if (sample_bit) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (load_word) begin
        if (!tx_ready_o) begin
          tx_shift   <= hold;
          tx_ready_o <= 1'b1;
        end else begin
          tx_shift      <= '0;
          tx_underrun_o <= 1'b1;
        end
      end else if (shift_word) begin
        tx_shift <= tx_next;
      end

      // With tx_ready_o low this is ignored, so a same-cycle word load keeps the old word.
      if (tx_load_i && tx_ready_o) begin
        hold       <= tx_data_i;
        tx_ready_o <= 1'b0;
      end
    end
  end

  assign busy_o    = (state == ACTIVE);
  assign miso_oe_o = busy_o;
  assign miso_o    = busy_o & tx_head;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances in different modes, a behavioural SPI master,
// a table of single-word frames and hand sequences for multi-word, abort and reset cases.
module tb_spi_slave_sync;
  localparam int HALF = 8;
  localparam int CPOL_T[4] = '{0, 0, 1, 0};
  localparam int CPHA_T[4] = '{0, 1, 1, 1};
  localparam int W_T[4]    = '{8, 8, 8, 16};
  localparam int MSB_T[4]  = '{1, 1, 1, 0};

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          idx;
    bit          load;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] miso;
    int          under;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  sclk;
  logic [3:0]  ss_n;
  logic        mosi;
  logic [3:0]  tx_load;
  logic [15:0] txd[4];
  logic [15:0] rxd[4];
  wire  [7:0]  rxd0, rxd1, rxd2;
  wire  [15:0] rxd3;
  wire  [3:0]  miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_error, busy;

  int   checks = 0;
  int   errors = 0;
  int   under_cnt[4];
  int   ferr_cnt[4];
  int   valid_cnt[4];
  exp_t exp_q[$];
  vec_t vecs[7];

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u0 (
    .sysClk_i(clk), .reset_i(rst), .sclk_i(sclk[0]), .mosi_i(mosi), .ss_i_n(ss_n[0]),
    .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .tx_data_i(txd[0][7:0]), .tx_load_i(tx_load[0]),
    .tx_ready_o(tx_ready[0]), .rx_data_o(rxd0), .rx_valid_o(rx_valid[0]),
    .tx_underrun_o(tx_underrun[0]), .frame_error_o(frame_error[0]), .busy_o(busy[0]));

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u1 (
    .sysClk_i(clk), .reset_i(rst), .sclk_i(sclk[1]), .mosi_i(mosi), .ss_i_n(ss_n[1]),
    .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .tx_data_i(txd[1][7:0]), .tx_load_i(tx_load[1]),
    .tx_ready_o(tx_ready[1]), .rx_data_o(rxd1), .rx_valid_o(rx_valid[1]),
    .tx_underrun_o(tx_underrun[1]), .frame_error_o(frame_error[1]), .busy_o(busy[1]));

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u2 (
    .sysClk_i(clk), .reset_i(rst), .sclk_i(sclk[2]), .mosi_i(mosi), .ss_i_n(ss_n[2]),
    .miso_o(miso[2]), .miso_oe_o(miso_oe[2]), .tx_data_i(txd[2][7:0]), .tx_load_i(tx_load[2]),
    .tx_ready_o(tx_ready[2]), .rx_data_o(rxd2), .rx_valid_o(rx_valid[2]),
    .tx_underrun_o(tx_underrun[2]), .frame_error_o(frame_error[2]), .busy_o(busy[2]));

  spi_slave_sync #(.DATA_WIDTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u3 (
    .sysClk_i(clk), .reset_i(rst), .sclk_i(sclk[3]), .mosi_i(mosi), .ss_i_n(ss_n[3]),
    .miso_o(miso[3]), .miso_oe_o(miso_oe[3]), .tx_data_i(txd[3]), .tx_load_i(tx_load[3]),
    .tx_ready_o(tx_ready[3]), .rx_data_o(rxd3), .rx_valid_o(rx_valid[3]),
    .tx_underrun_o(tx_underrun[3]), .frame_error_o(frame_error[3]), .busy_o(busy[3]));

  always_comb begin
    rxd[0] = {8'h00, rxd0};
    rxd[1] = {8'h00, rxd1};
    rxd[2] = {8'h00, rxd2};
    rxd[3] = rxd3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to be done", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        valid_cnt[i]++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: instance %0d got %0h, expected no word", i, rxd[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_instance", i, 32'(e.idx));
          check("rx_word", {16'h0, rxd[i]}, {16'h0, e.data});
        end
      end
      if (tx_underrun[i]) under_cnt[i]++;
      if (frame_error[i]) ferr_cnt[i]++;
    end
  end

  // Behavioural master: nbits bits of mo in the instance's bit order, MISO captured
  // at the master's sample point of each bit.
  task automatic spi_word(input int idx, input logic [15:0] mo, input int nbits,
                          output logic [15:0] mi);
    int pos;
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      pos = (MSB_T[idx] != 0) ? W_T[idx] - 1 - b : b;
      if (CPHA_T[idx] == 0) begin
        mosi = mo[pos];
        wait_cyc(HALF);
        mi[pos] = miso[idx];
        sclk[idx] = ~sclk[idx];
        wait_cyc(HALF);
        sclk[idx] = ~sclk[idx];
      end else begin
        sclk[idx] = ~sclk[idx];
        mosi = mo[pos];
        wait_cyc(HALF);
        mi[pos] = miso[idx];
        sclk[idx] = ~sclk[idx];
        wait_cyc(HALF);
      end
    end
  endtask

  task automatic end_frame(input int idx);
    wait_cyc(HALF);
    ss_n[idx] = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic load_tx(input int idx, input logic [15:0] d);
    txd[idx] = d;
    tx_load[idx] = 1'b1;
    @(negedge clk);
    tx_load[idx] = 1'b0;
  endtask

  initial begin
    logic [15:0] mi;
    int          i;
    int          u0;
    int          f0;
    int          v0;
    int          k;

    // Mode 0 frames also consume the holding register on the trailing edge after the
    // last bit, so an empty holding register there adds one underrun.
    vecs[0] = '{0, 1'b1, 16'h00A5, 16'h003C, 16'h00A5, 1};
    vecs[1] = '{1, 1'b0, 16'h0000, 16'h0055, 16'h0000, 1};
    vecs[2] = '{3, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF, 0};
    vecs[3] = '{2, 1'b1, 16'h005A, 16'h0096, 16'h005A, 0};
    vecs[4] = '{0, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 2};
    vecs[5] = '{3, 1'b0, 16'h0000, 16'h8001, 16'h0000, 1};
    vecs[6] = '{1, 1'b1, 16'h00C3, 16'h0000, 16'h00C3, 0};

    for (int n = 0; n < 4; n++) begin
      under_cnt[n] = 0;
      ferr_cnt[n]  = 0;
      valid_cnt[n] = 0;
      txd[n]       = '0;
    end
    rst     = 1'b1;
    sclk    = 4'b0100;
    ss_n    = 4'hF;
    mosi    = 1'b0;
    tx_load = 4'h0;
    wait_cyc(4);
    for (int n = 0; n < 4; n++) begin
      check("reset_tx_ready", tx_ready[n], 1);
      check("reset_busy", busy[n], 0);
      check("reset_miso_oe", miso_oe[n], 0);
      check("reset_rx_data", {16'h0, rxd[n]}, 0);
    end
    rst = 1'b0;
    wait_cyc(4);
    check("idle_no_underrun", under_cnt[0] + under_cnt[2], 0);

    for (int v = 0; v < 7; v++) begin
      i  = vecs[v].idx;
      u0 = under_cnt[i];
      f0 = ferr_cnt[i];
      if (vecs[v].load) begin
        load_tx(i, vecs[v].tx);
        check("tx_ready_after_load", tx_ready[i], 0);
      end
      exp_q.push_back('{2'(i), vecs[v].mo});
      ss_n[i] = 1'b0;
      if (vecs[v].load && CPHA_T[i] == 0) begin
        wait_cyc(3);
        check("tx_ready_ss_plus3", tx_ready[i], 0);
        wait_cyc(1);
        check("tx_ready_ss_plus4", tx_ready[i], 1);
        wait_cyc(HALF - 4);
      end else begin
        wait_cyc(HALF);
      end
      check("busy_in_frame", busy[i], 1);
      spi_word(i, vecs[v].mo, W_T[i], mi);
      check("miso_word", mi, vecs[v].miso);
      end_frame(i);
      check("underruns", under_cnt[i] - u0, vecs[v].under);
      check("no_frame_error", ferr_cnt[i] - f0, 0);
      check("tx_ready_end", tx_ready[i], 1);
      check("busy_end", busy[i], 0);
    end

    // Mode 3, two words in one frame with a reload while the first word shifts.
    u0 = under_cnt[2];
    load_tx(2, 16'h0012);
    exp_q.push_back('{2'd2, 16'h00F0});
    exp_q.push_back('{2'd2, 16'h000F});
    ss_n[2] = 1'b0;
    wait_cyc(HALF);
    fork
      spi_word(2, 16'h00F0, 8, mi);
      begin : reload
        k = 0;
        while (!tx_ready[2] && k < 40) begin
          @(negedge clk);
          k++;
        end
        check("reload_ready", tx_ready[2], 1);
        load_tx(2, 16'h0034);
      end
    join
    check("miso_word1_mode3", mi, 16'h0012);
    spi_word(2, 16'h000F, 8, mi);
    check("miso_word2_mode3", mi, 16'h0034);
    end_frame(2);
    check("mode3_no_underrun", under_cnt[2] - u0, 0);
    check("mode3_rx_data", {16'h0, rxd[2]}, 32'h0F);

    // Mode 0 abort after 5 sample edges, then a clean frame.
    f0 = ferr_cnt[0];
    v0 = valid_cnt[0];
    ss_n[0] = 1'b0;
    wait_cyc(HALF);
    spi_word(0, 16'h00AA, 5, mi);
    end_frame(0);
    check("abort_frame_error", ferr_cnt[0] - f0, 1);
    check("abort_no_rx_valid", valid_cnt[0] - v0, 0);
    exp_q.push_back('{2'd0, 16'h0081});
    ss_n[0] = 1'b0;
    wait_cyc(HALF);
    spi_word(0, 16'h0081, 8, mi);
    end_frame(0);
    check("after_abort_rx_data", {16'h0, rxd[0]}, 32'h81);
    check("after_abort_no_error", ferr_cnt[0] - f0, 1);

    // Reset three bits into a mode 0 frame, then a fresh frame.
    load_tx(0, 16'h00FF);
    ss_n[0] = 1'b0;
    wait_cyc(HALF);
    spi_word(0, 16'h00C3, 3, mi);
    rst = 1'b1;
    wait_cyc(2);
    check("rst_busy", busy[0], 0);
    check("rst_miso", miso[0], 0);
    check("rst_miso_oe", miso_oe[0], 0);
    check("rst_tx_ready", tx_ready[0], 1);
    check("rst_rx_data", {16'h0, rxd[0]}, 0);
    check("rst_rx_valid", rx_valid[0], 0);
    rst = 1'b0;
    end_frame(0);
    f0 = ferr_cnt[0];
    exp_q.push_back('{2'd0, 16'h00C3});
    ss_n[0] = 1'b0;
    wait_cyc(HALF);
    spi_word(0, 16'h00C3, 8, mi);
    end_frame(0);
    check("post_reset_rx_data", {16'h0, rxd[0]}, 32'hC3);
    check("post_reset_no_error", ferr_cnt[0] - f0, 0);

    wait_cyc(4);
    check("rx_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
